stopwatch_bcd_core: RTL

//  MM:SS stopwatch core. Consumes the 1 Hz single-cycle enable tick from the seconds prescaler.

---
 rtl/stopwatch_bcd_core_if.sv | 36 +++
 rtl/stopwatch_bcd_core.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd_core_if.sv
// Stopwatch core bus: tick and raw key inputs in, four BCD digits plus status out.
// Latency: none, wires only.
// Backpressure: none; the tick is a strobe and the outputs are levels.
// Defining STOPWATCH_LAP_EN adds the key_lap_n line.
interface stopwatch_bcd_core_if;
  logic       tick;
  logic       key_startstop_n;
  logic       key_clear_n;
`ifdef STOPWATCH_LAP_EN
  logic       key_lap_n;
`endif
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       running;
  logic       rollover;

  // Upstream side: prescaler tick, board keys, display decoders
  modport master (
`ifdef STOPWATCH_LAP_EN
    output key_lap_n,
`endif
    output tick, key_startstop_n, key_clear_n,
    input  sec_ones, sec_tens, min_ones, min_tens, running, rollover
  );

  // Stopwatch core side
  modport slave (
`ifdef STOPWATCH_LAP_EN
    input  key_lap_n,
`endif
    input  tick, key_startstop_n, key_clear_n,
    output sec_ones, sec_tens, min_ones, min_tens, running, rollover
  );
endinterface

// File: rtl/stopwatch_bcd_core.sv
// MM:SS BCD stopwatch with start/pause/clear FSM driven by raw active-low keys.
// Latency: key press -> internal pulse SYNC_STAGES+1 cycles; a counted tick shows the new digits the next cycle.
// Backpressure: none; every tick seen in RUN is counted, keys are sampled every cycle.
// Optional lap/freeze display feature is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_bcd_core #(
  parameter int SYNC_STAGES = 2,   // legal 2..4
  parameter int MIN_LIMIT   = 59   // last minute value before rollover, 1..99
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  stopwatch_bcd_core_if.slave  bus
);

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;

  localparam logic [3:0] LIM_TENS = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] LIM_ONES = 4'(MIN_LIMIT % 10);

  // Key slots in the conditioning vectors
  localparam int K_START = 0;
  localparam int K_CLEAR = 1;
`ifdef STOPWATCH_LAP_EN
  localparam int K_LAP   = 2;
  localparam int NKEYS   = 3;
`else
  localparam int NKEYS   = 2;
`endif

  logic [NKEYS-1:0] key_raw;
  logic [NKEYS-1:0] sync_q [SYNC_STAGES];
  logic [NKEYS-1:0] prev_q;
  logic [NKEYS-1:0] press_q;

  state_t    state_q, state_d;
  bcd_time_t cnt_q, cnt_inc, disp;
  logic      zero_cnt;
  logic      count_en;
  logic      at_limit;
  logic      running_q;
  logic      rollover_q;
  logic      start_p, clr_p;

`ifdef STOPWATCH_LAP_EN
  assign key_raw = {bus.key_lap_n, bus.key_clear_n, bus.key_startstop_n};
`else
  assign key_raw = {bus.key_clear_n, bus.key_startstop_n};
`endif

  // Synchronise raw keys (released = 1) and emit one pulse per falling edge of the settled level
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
      prev_q  <= '1;
      press_q <= '0;
    end else begin
      sync_q[0] <= key_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q  <= sync_q[SYNC_STAGES-1];
      press_q <= prev_q & ~sync_q[SYNC_STAGES-1];
    end
  end

  assign start_p = press_q[K_START];
  assign clr_p   = press_q[K_CLEAR];

  // FSM state register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state: clear beats start when stopped, start beats clear when running
  always_comb begin
    state_d  = state_q;
    zero_cnt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_p)        zero_cnt = 1'b1;
        else if (start_p) state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (start_p) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (clr_p) begin
          state_d  = ST_IDLE;
          zero_cnt = 1'b1;
        end else if (start_p) begin
          state_d  = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ticks count only against the registered state, so the edge leaving RUN still counts
  // and the edge entering RUN does not.
  assign count_en = (state_q == ST_RUN) && bus.tick;
  assign at_limit = (cnt_q.min_tens == LIM_TENS) && (cnt_q.min_ones == LIM_ONES) &&
                    (cnt_q.sec_tens == 4'd5)     && (cnt_q.sec_ones == 4'd9);

  // BCD increment with carry from seconds into minutes, wrapping to 00:00 at the limit
  always_comb begin
    cnt_inc = cnt_q;
    if (at_limit) begin
      cnt_inc = '0;
    end else if (cnt_q.sec_ones != 4'd9) begin
      cnt_inc.sec_ones = cnt_q.sec_ones + 4'd1;
    end else begin
      cnt_inc.sec_ones = 4'd0;
      if (cnt_q.sec_tens != 4'd5) begin
        cnt_inc.sec_tens = cnt_q.sec_tens + 4'd1;
      end else begin
        cnt_inc.sec_tens = 4'd0;
        if (cnt_q.min_ones != 4'd9) begin
          cnt_inc.min_ones = cnt_q.min_ones + 4'd1;
        end else begin
          cnt_inc.min_ones = 4'd0;
          cnt_inc.min_tens = cnt_q.min_tens + 4'd1;
        end
      end
    end
  end

  // Time count, rollover strobe and registered running flag
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      running_q  <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      running_q  <= (state_q == ST_RUN);
      rollover_q <= count_en && at_limit;
      if (zero_cnt)      cnt_q <= '0;
      else if (count_en) cnt_q <= cnt_inc;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic      frozen_q;
  bcd_time_t lap_q;

  // Lap press while running toggles the display freeze; clearing back to IDLE releases it
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      frozen_q <= 1'b0;
      lap_q    <= '0;
    end else if (zero_cnt) begin
      frozen_q <= 1'b0;
    end else if ((state_q == ST_RUN) && press_q[K_LAP]) begin
      frozen_q <= ~frozen_q;
      lap_q    <= cnt_q;
    end
  end

  assign disp = frozen_q ? lap_q : cnt_q;
`else
  assign disp = cnt_q;
`endif

  assign bus.sec_ones = disp.sec_ones;
  assign bus.sec_tens = disp.sec_tens;
  assign bus.min_ones = disp.min_ones;
  assign bus.min_tens = disp.min_tens;
  assign bus.running  = running_q;
  assign bus.rollover = rollover_q;

endmodule
